// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and widths for the instruction fetch controller.
//   ADDR_W / INSTR_W   : PROM address and instruction word widths
//   OP_HI / OP_LO      : opcode field bounds inside an instruction word
//   fetch_state_e      : controller state encoding
package fetch_ctrl_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 15;
  localparam int unsigned OP_HI   = 14;
  localparam int unsigned OP_LO   = 11;
  localparam int unsigned OP_W    = OP_HI - OP_LO + 1;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [OP_W-1:0]    opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: control, consumer handshake and PROM bus of the fetch controller.
//   START/HALT/STALL/JUMP/JUMP_ADDR : control inputs to the controller
//   PROM_OUT / P_COUNT              : registered PROM data in / address out
//   INSTR/INSTR_VALID               : instruction handed to the consumer
//   BUSY/HALTED                     : status
// modport master = fetch_ctrl side, modport slave = environment side.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic   START;
  logic   HALT;
  logic   STALL;
  logic   JUMP;
  addr_t  JUMP_ADDR;
  instr_t PROM_OUT;
  addr_t  P_COUNT;
  instr_t INSTR;
  logic   INSTR_VALID;
  logic   BUSY;
  logic   HALTED;

  modport master (
    input  START, HALT, STALL, JUMP, JUMP_ADDR, PROM_OUT,
    output P_COUNT, INSTR, INSTR_VALID, BUSY, HALTED
  );

  modport slave (
    output START, HALT, STALL, JUMP, JUMP_ADDR, PROM_OUT,
    input  P_COUNT, INSTR, INSTR_VALID, BUSY, HALTED
  );

endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetches instruction words from a registered PROM and hands them
// to a consumer with a valid/stall handshake. One instruction per 3 cycles
// (ISSUE -> CAPTURE -> HOLD) when the consumer never stalls.
// Ports:
//   CLK_FT  : clock, all state changes on rising edge
//   RESET   : synchronous active-high reset
//   bus     : fetch_ctrl_if.master (control, PROM bus, consumer handshake)
//   BP_ADDR : breakpoint address     (only with FETCH_CTRL_BREAKPOINT_EN)
//   BP_HIT  : sticky breakpoint flag (only with FETCH_CTRL_BREAKPOINT_EN)
// Parameters: RESET_PC (fetch address after reset), HALT_OP (stop opcode).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t   RESET_PC = 8'h00,
  parameter opcode_t HALT_OP  = 4'hF
) (
  input  logic              CLK_FT,
  input  logic              RESET,
`ifdef FETCH_CTRL_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] BP_ADDR,
  output logic              BP_HIT,
`endif
  fetch_ctrl_if.master      bus
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        p_count_q, p_count_d;
  instr_t       instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         halted_q, halted_d;
  addr_t        nxt_addr;
`ifdef FETCH_CTRL_BREAKPOINT_EN
  logic         bp_hit_q, bp_hit_d;
`endif

  function automatic addr_t next_addr(input logic jump, input addr_t jump_addr,
                                      input addr_t pc);
    return jump ? jump_addr : pc;
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    p_count_d = p_count_q;
    instr_d   = instr_q;
    halted_d  = halted_q;
`ifdef FETCH_CTRL_BREAKPOINT_EN
    bp_hit_d  = bp_hit_q;
`endif
    nxt_addr  = next_addr(bus.JUMP, bus.JUMP_ADDR, pc_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.START && !bus.HALT) begin
          p_count_d = pc_q;
          halted_d  = 1'b0;
`ifdef FETCH_CTRL_BREAKPOINT_EN
          bp_hit_d  = 1'b0;
`endif
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        instr_d = bus.PROM_OUT;
        pc_d    = p_count_q + 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Acceptance: PC always takes the (possibly redirected) next address,
        // so a stop resumes from exactly where the stream would have gone.
        if (!bus.STALL) begin
          pc_d = nxt_addr;
          if (instr_q[OP_HI:OP_LO] == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (bus.HALT) begin
            state_d  = ST_IDLE;
          end
`ifdef FETCH_CTRL_BREAKPOINT_EN
          else if (nxt_addr == BP_ADDR) begin
            bp_hit_d = 1'b1;
            state_d  = ST_IDLE;
          end
`endif
          else begin
            p_count_d = nxt_addr;
            state_d   = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    valid_d = (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_FT) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      p_count_q <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
`ifdef FETCH_CTRL_BREAKPOINT_EN
      bp_hit_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      p_count_q <= p_count_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
`ifdef FETCH_CTRL_BREAKPOINT_EN
      bp_hit_q  <= bp_hit_d;
`endif
    end
  end

  assign bus.P_COUNT     = p_count_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.BUSY        = busy_q;
  assign bus.HALTED      = halted_q;
`ifdef FETCH_CTRL_BREAKPOINT_EN
  assign BP_HIT          = bp_hit_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A cycle table, a few
// directed sequences and a random run checked against a transaction-level
// model of the fetch stream. Breakpoint checks exist only when
// FETCH_CTRL_BREAKPOINT_EN is defined.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
`ifdef FETCH_CTRL_BREAKPOINT_EN
  addr_t bp_addr = 8'hEE;
  logic  bp_hit;
`endif

  fetch_ctrl #(.RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
    .CLK_FT (clk),
    .RESET  (rst),
`ifdef FETCH_CTRL_BREAKPOINT_EN
    .BP_ADDR(bp_addr),
    .BP_HIT (bp_hit),
`endif
    .bus    (bus)
  );

  // Registered PROM: data appears one edge after the address.
  instr_t mem [256];
  always @(posedge clk) bus.PROM_OUT <= mem[bus.P_COUNT];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic h, input logic st, input logic j,
                       input addr_t ja);
    bus.START     = s;
    bus.HALT      = h;
    bus.STALL     = st;
    bus.JUMP      = j;
    bus.JUMP_ADDR = ja;
  endtask

  task automatic drive_junk();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), addr_t'($urandom));
  endtask

  // Ticks once with the inputs already driven (START or acceptance), then
  // with junk until INSTR_VALID, bounded; checks the edge count.
  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    do begin
      tick();
      n++;
      if (!bus.INSTR_VALID) drive_junk();
    end while (!bus.INSTR_VALID && n < 12);
    chk({tag, ".latency"}, n, exp_n);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hAB);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 15'h0100 + 15'(i);
    mem[0]  = 15'h0123;
    mem[5]  = 15'h7800;
  endtask

  typedef struct {
    logic   start, halt, stall, jump;
    addr_t  jaddr;
    addr_t  pc;
    instr_t instr;
    logic   valid, busy, halted;
  } vec_t;

  function automatic vec_t mk(logic s, logic h, logic st, logic j, addr_t ja,
                              addr_t pc, instr_t ins, logic v, logic b, logic hd);
    vec_t r;
    r.start = s; r.halt = h; r.stall = st; r.jump = j; r.jaddr = ja;
    r.pc = pc; r.instr = ins; r.valid = v; r.busy = b; r.halted = hd;
    return r;
  endfunction

  initial begin
    vec_t   tbl[$];
    addr_t  exp_pc, nxt;
    logic   exp_halted, jmp, hlt, cont;
    addr_t  ja;
    int     fetches;
`ifdef FETCH_CTRL_BREAKPOINT_EN
    logic   exp_bp;
`endif

    load_program();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---------------- reset state (RESET dominates START/JUMP) -------------
    reset_dut();
    chk("reset.pcount", bus.P_COUNT, 8'h00);
    chk("reset.instr",  bus.INSTR, 15'h0000);
    chk("reset.valid",  bus.INSTR_VALID, 1'b0);
    chk("reset.busy",   bus.BUSY, 1'b0);
    chk("reset.halted", bus.HALTED, 1'b0);
`ifdef FETCH_CTRL_BREAKPOINT_EN
    chk("reset.bp_hit", bp_hit, 1'b0);
`endif

    // ---------------- cycle table -------------------------------------------
    //            s  h  st j  ja     | pc     instr     v  b  hd
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 15'h0000, 0, 1, 0)); // START -> ISSUE
    tbl.push_back(mk(0, 1, 1, 1, 8'h40, 8'h00, 15'h0000, 0, 1, 0)); // ISSUE ignores junk
    tbl.push_back(mk(0, 1, 1, 1, 8'h40, 8'h00, 15'h0123, 1, 1, 0)); // CAPTURE -> HOLD
    tbl.push_back(mk(0, 1, 1, 1, 8'h33, 8'h00, 15'h0123, 1, 1, 0)); // stalled
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 15'h0123, 1, 1, 0)); // stalled
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 15'h0123, 0, 1, 0)); // accept
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h01, 15'h0123, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 15'h0101, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h02, 15'h0101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h02, 15'h0101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h02, 15'h0102, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h10, 8'h10, 15'h0102, 0, 1, 0)); // jump on accept
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h10, 15'h0102, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h10, 15'h0110, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h10, 15'h0110, 0, 0, 0)); // HALT -> IDLE
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 8'h10, 15'h0110, 0, 0, 0)); // START blocked
    tbl.push_back(mk(0, 0, 1, 1, 8'h55, 8'h10, 15'h0110, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h11, 15'h0110, 0, 1, 0)); // resume at PC
    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].halt, tbl[i].stall, tbl[i].jump, tbl[i].jaddr);
      tick();
      chk($sformatf("row%0d.pcount", i), bus.P_COUNT, tbl[i].pc);
      chk($sformatf("row%0d.instr", i),  bus.INSTR, tbl[i].instr);
      chk($sformatf("row%0d.valid", i),  bus.INSTR_VALID, tbl[i].valid);
      chk($sformatf("row%0d.busy", i),   bus.BUSY, tbl[i].busy);
      chk($sformatf("row%0d.halted", i), bus.HALTED, tbl[i].halted);
    end

    // ---------------- five-cycle stall --------------------------------------
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid("stall.start", 3);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
      tick();
      chk($sformatf("stall%0d.valid", i),  bus.INSTR_VALID, 1'b1);
      chk($sformatf("stall%0d.instr", i),  bus.INSTR, 15'h0123);
      chk($sformatf("stall%0d.pcount", i), bus.P_COUNT, 8'h00);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("stall.release.pcount", bus.P_COUNT, 8'h01);
    chk("stall.release.valid",  bus.INSTR_VALID, 1'b0);

    // ---------------- HALT_OP instruction at 05 -----------------------------
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid("haltop.start", 3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("haltop.instr%0d", k), bus.INSTR, mem[k]);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      wait_valid($sformatf("haltop.acc%0d", k), 3);
    end
    chk("haltop.instr5", bus.INSTR, 15'h7800);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("haltop.busy",   bus.BUSY, 1'b0);
    chk("haltop.halted", bus.HALTED, 1'b1);
    chk("haltop.valid",  bus.INSTR_VALID, 1'b0);
    tick();
    chk("haltop.sticky", bus.HALTED, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("haltop.resume.halted", bus.HALTED, 1'b0);
    chk("haltop.resume.pcount", bus.P_COUNT, 8'h06);

    // ---------------- PC wrap at FF and reset during CAPTURE ----------------
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid("wrap.start", 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    wait_valid("wrap.jump", 3);
    chk("wrap.pcount", bus.P_COUNT, 8'hFF);
    chk("wrap.instr",  bus.INSTR, mem[255]);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("wrap.idle", bus.BUSY, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("wrap.pc00", bus.P_COUNT, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid("rstcap.first", 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();                                  // accept -> ISSUE at 01
    tick();                                  // CAPTURE at 01
    chk("rstcap.pre.pcount", bus.P_COUNT, 8'h01);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rstcap.pcount", bus.P_COUNT, 8'h00);
    chk("rstcap.valid",  bus.INSTR_VALID, 1'b0);
    chk("rstcap.busy",   bus.BUSY, 1'b0);
    chk("rstcap.instr",  bus.INSTR, 15'h0000);
    tick();
    chk("rstcap.stays_idle", bus.BUSY, 1'b0);

`ifdef FETCH_CTRL_BREAKPOINT_EN
    // ---------------- breakpoint at 03 --------------------------------------
    bp_addr = 8'h03;
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid("bp.start", 3);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      wait_valid($sformatf("bp.acc%0d", k), 3);
    end
    chk("bp.instr2", bus.INSTR, mem[2]);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("bp.busy",   bus.BUSY, 1'b0);
    chk("bp.hit",    bp_hit, 1'b1);
    chk("bp.halted", bus.HALTED, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("bp.resume.hit",    bp_hit, 1'b0);
    chk("bp.resume.pcount", bus.P_COUNT, 8'h03);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid("bp.resume", 2);
    chk("bp.resume.instr", bus.INSTR, mem[3]);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("bp.next.pcount", bus.P_COUNT, 8'h04);
    chk("bp.next.busy",   bus.BUSY, 1'b1);
    bp_addr = 8'hEE;
`endif

    // ---------------- random run vs. fetch-stream model ---------------------
    for (int i = 0; i < 256; i++) mem[i] = instr_t'($urandom);
    reset_dut();
    exp_pc     = 8'h00;
    exp_halted = 1'b0;
    for (int ep = 0; ep < 60; ep++) begin
`ifdef FETCH_CTRL_BREAKPOINT_EN
      bp_addr = addr_t'($urandom);
      exp_bp  = 1'b0;
`endif
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), addr_t'($urandom));
        tick();
        chk("rnd.start_blocked", bus.BUSY, 1'b0);
      end
      drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), addr_t'($urandom));
      exp_halted = 1'b0;
      wait_valid("rnd.start", 3);
      chk("rnd.start.halted", bus.HALTED, exp_halted);
      fetches = 0;
      cont    = 1'b1;
      while (cont) begin
        fetches++;
        chk("rnd.pcount", bus.P_COUNT, exp_pc);
        chk("rnd.instr",  bus.INSTR, mem[exp_pc]);
        for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
          drive(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), addr_t'($urandom));
          tick();
          chk("rnd.stall.valid", bus.INSTR_VALID, 1'b1);
          chk("rnd.stall.instr", bus.INSTR, mem[exp_pc]);
        end
        jmp = ($urandom_range(0, 3) == 0);
        ja  = addr_t'($urandom);
        hlt = ($urandom_range(0, 7) == 0) || (fetches >= 25);
        drive(1'($urandom), hlt, 1'b0, jmp, ja);
        nxt = jmp ? ja : exp_pc + 8'd1;
        if (mem[exp_pc][OP_HI:OP_LO] == 4'hF) begin
          cont = 1'b0;
          exp_halted = 1'b1;
        end else if (hlt) begin
          cont = 1'b0;
        end
`ifdef FETCH_CTRL_BREAKPOINT_EN
        else if (nxt == bp_addr) begin
          cont   = 1'b0;
          exp_bp = 1'b1;
        end
`endif
        exp_pc = nxt;
        if (cont) begin
          wait_valid("rnd.accept", 3);
        end else begin
          tick();
          chk("rnd.stop.busy",   bus.BUSY, 1'b0);
          chk("rnd.stop.valid",  bus.INSTR_VALID, 1'b0);
          chk("rnd.stop.halted", bus.HALTED, exp_halted);
`ifdef FETCH_CTRL_BREAKPOINT_EN
          chk("rnd.stop.bp_hit", bp_hit, exp_bp);
`endif
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
